// File: rtl/lc3b_evict_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_evict_buffer
// Purpose  : Write-back eviction buffer between the L1 data cache and memory.
//            Dirty lines are queued in FIFO order, drained one at a time,
//            visible to miss lookups, and coalesced on re-eviction.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_evict_buffer #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = 4,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [ADDR_WIDTH-1:0]      enq_addr,
    input  logic [DATA_WIDTH-1:0]      enq_data,
    input  logic [ADDR_WIDTH-1:0]      lkp_addr,
    output logic                       lkp_hit,
    output logic [DATA_WIDTH-1:0]      lkp_data,
    output logic                       mem_write,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_resp,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    flush_pending_q;
    logic                    flush_done_q;
    logic [DEPTH-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [DEPTH];
    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [TAG_W-1:0]        enq_tag, lkp_tag;
    logic                    head_locked;
    logic                    coal_hit;
    logic [PTR_W-1:0]        coal_idx;
    logic                    do_coal, do_app, do_pop;
    logic                    unused_bits;

    assign enq_tag     = enq_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign lkp_tag     = lkp_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_bits = ^{enq_addr[OFFSET_BITS-1:0], lkp_addr[OFFSET_BITS-1:0]};

    // The head entry is frozen for the whole memory write.
    assign head_locked = (state_q == S_WRITE);

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;
    assign enq_ready  = !full || coal_hit;
    assign mem_write  = head_locked;
    assign mem_address = {tag_q[head_q], {OFFSET_BITS{1'b0}}};
    assign mem_wdata  = data_q[head_q];
    assign flush_done = flush_done_q;

    assign do_coal = enq_valid && coal_hit;
    assign do_app  = enq_valid && !coal_hit && !full;
    assign do_pop  = head_locked && mem_resp;

    // Find the (at most one) unlocked valid entry matching the enqueue tag.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !(head_locked && (PTR_W'(i) == head_q)) &&
                (tag_q[i] == enq_tag)) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    // Miss lookup: an unlocked match is newer than the locked head copy.
    always_comb begin
        lkp_hit  = 1'b0;
        lkp_data = '0;
        if (head_locked && valid_q[head_q] && (tag_q[head_q] == lkp_tag)) begin
            lkp_hit  = 1'b1;
            lkp_data = data_q[head_q];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !(head_locked && (PTR_W'(i) == head_q)) &&
                (tag_q[i] == lkp_tag)) begin
                lkp_hit  = 1'b1;
                lkp_data = data_q[i];
            end
        end
    end

    // Next pointers and occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (do_app) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (do_app && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_app && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Valid bits, pointers and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (do_app) begin
                valid_q[tail_q] <= 1'b1;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Line payload storage; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (do_app) begin
            tag_q[tail_q]  <= enq_tag;
            data_q[tail_q] <= enq_data;
        end else if (do_coal) begin
            data_q[coal_idx] <= enq_data;
        end
    end

    // Drain FSM with flush tracking; IDLE always separates consecutive writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (!empty) begin
                    state_q <= S_WRITE;
                end
            end else begin
                if (mem_resp) begin
                    state_q <= S_IDLE;
                end
            end
            if ((flush_pending_q || flush_req) && (state_q == S_IDLE) && empty) begin
                flush_pending_q <= 1'b0;
                flush_done_q    <= 1'b1;
            end else if (flush_req) begin
                flush_pending_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3b_evict_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_evict_buffer
// Purpose  : Self-checking bench for lc3b_evict_buffer; expected memory writes
//            are queued by the stimulus and compared by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_evict_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enq_valid;
    logic         enq_ready;
    logic [15:0]  enq_addr;
    logic [127:0] enq_data;
    logic [15:0]  lkp_addr;
    logic         lkp_hit;
    logic [127:0] lkp_data;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic         flush_req;
    logic         flush_done;
    logic         empty;
    logic         full;
    logic [2:0]   count;

    lc3b_evict_buffer #(
        .DATA_WIDTH (128),
        .ADDR_WIDTH (16),
        .OFFSET_BITS(4),
        .DEPTH      (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_addr   (enq_addr),
        .enq_data   (enq_data),
        .lkp_addr   (lkp_addr),
        .lkp_hit    (lkp_hit),
        .lkp_data   (lkp_data),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks  = 0;
    int  n_pass    = 0;
    int  flush_cnt = 0;

    localparam logic [127:0] D_A   = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] D_1   = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    localparam logic [127:0] D_2   = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [127:0] D_3   = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    localparam logic [127:0] D_3B  = 128'h3B3B_3B3B_3B3B_3B3B_3B3B_3B3B_3B3B_3B3B;
    localparam logic [127:0] D_4   = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    localparam logic [127:0] D_OLD = 128'h0DD0_0DD0_0DD0_0DD0_0DD0_0DD0_0DD0_0DD0;
    localparam logic [127:0] D_B   = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input string name);
        int n = 0;
        while (!mem_write && n < 8) begin
            step();
            n++;
        end
        check(name, {127'b0, mem_write}, 128'd1);
    endtask

    task automatic resp();
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
    endtask

    task automatic enq(input logic [15:0] a, input logic [127:0] d);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        step();
        enq_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [127:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            wait_write(name);
            resp();
        end
    endtask

    // Monitor: every completed memory write must match the queue head.
    always @(negedge clk) begin
        if (rst_n && mem_write && mem_resp) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write actual=%h required=none", mem_address);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {112'b0, mem_address}, {112'b0, mon_e.addr});
                check("wr_data", mem_wdata, mon_e.data);
            end
        end
        if (flush_done) begin
            flush_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        enq_valid = 1'b0;
        enq_addr  = '0;
        enq_data  = '0;
        lkp_addr  = '0;
        mem_resp  = 1'b0;
        flush_req = 1'b0;
        step();
        step();

        // Reset state
        check("rst_count", {125'b0, count}, 128'd0);
        check("rst_empty", {127'b0, empty}, 128'd1);
        check("rst_full", {127'b0, full}, 128'd0);
        check("rst_memwrite", {127'b0, mem_write}, 128'd0);
        check("rst_flushdone", {127'b0, flush_done}, 128'd0);
        check("rst_enqready", {127'b0, enq_ready}, 128'd1);
        rst_n = 1'b1;

        // Single line through to memory
        push_exp(16'h1230, D_A);
        enq(16'h1230, D_A);
        check("s1_count", {125'b0, count}, 128'd1);
        wait_write("s1_write");
        check("s1_addr", {112'b0, mem_address}, 128'h1230);
        check("s1_wdata", mem_wdata, D_A);
        lkp_addr = 16'h123C;
        #1;
        check("s1_lkp_hit", {127'b0, lkp_hit}, 128'd1);
        check("s1_lkp_data", lkp_data, D_A);
        resp();
        check("s1_count0", {125'b0, count}, 128'd0);
        check("s1_empty", {127'b0, empty}, 128'd1);
        check("s1_memwrite0", {127'b0, mem_write}, 128'd0);
        check("s1_lkp_miss", {127'b0, lkp_hit}, 128'd0);
        check("s1_lkp_zero", lkp_data, 128'd0);

        // Fill to full, reject new tag, coalesce into queued tag
        push_exp(16'h1000, D_1);
        push_exp(16'h2000, D_2);
        push_exp(16'h3000, D_3B);
        push_exp(16'h4000, D_4);
        enq(16'h1000, D_1);
        enq(16'h2000, D_2);
        enq(16'h3000, D_3);
        enq(16'h4000, D_4);
        check("s2_full", {127'b0, full}, 128'd1);
        check("s2_count4", {125'b0, count}, 128'd4);
        enq_addr = 16'h5000;
        #1;
        check("s2_ready_new", {127'b0, enq_ready}, 128'd0);
        enq_addr = 16'h3000;
        #1;
        check("s2_ready_coal", {127'b0, enq_ready}, 128'd1);
        enq(16'h3000, D_3B);
        check("s2_count_coal", {125'b0, count}, 128'd4);
        lkp_addr = 16'h3004;
        #1;
        check("s2_lkp_data", lkp_data, D_3B);
        drain(4, "s2_write");
        check("s2_empty", {127'b0, empty}, 128'd1);

        // Re-evict the line currently being written
        push_exp(16'h1000, D_OLD);
        push_exp(16'h1000, D_B);
        enq(16'h1000, D_OLD);
        wait_write("s3_write");
        enq(16'h1000, D_B);
        check("s3_count2", {125'b0, count}, 128'd2);
        check("s3_wdata_old", mem_wdata, D_OLD);
        lkp_addr = 16'h1008;
        #1;
        check("s3_lkp_hit", {127'b0, lkp_hit}, 128'd1);
        check("s3_lkp_new", lkp_data, D_B);
        drain(2, "s3_write");

        // Same-cycle pop and append, wrapping pointers over 3*DEPTH operations
        push_exp(16'h6000, {8{16'h6000}});
        enq(16'h6000, {8{16'h6000}});
        for (int k = 1; k <= 12; k++) begin
            logic [15:0] a;
            a = 16'h6000 + 16'(k * 16'h0110);
            wait_write("s4_write");
            push_exp(a, {8{a}});
            mem_resp  = 1'b1;
            enq_valid = 1'b1;
            enq_addr  = a;
            enq_data  = {8{a}};
            step();
            mem_resp  = 1'b0;
            enq_valid = 1'b0;
            check("s4_count", {125'b0, count}, 128'd1);
        end
        drain(1, "s4_write");

        // Flush with three lines queued
        push_exp(16'h7000, D_1);
        push_exp(16'h7100, D_2);
        push_exp(16'h7200, D_3);
        enq(16'h7000, D_1);
        enq(16'h7100, D_2);
        enq(16'h7200, D_3);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        drain(3, "s5_write");
        check("s5_done_early", {127'b0, flush_done}, 128'd0);
        step();
        check("s5_done_pulse", {127'b0, flush_done}, 128'd1);
        step();
        check("s5_done_clear", {127'b0, flush_done}, 128'd0);
        check("s5_flush_cnt1", flush_cnt, 128'd1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("s5_empty_done", {127'b0, flush_done}, 128'd1);
        step();
        check("s5_empty_clear", {127'b0, flush_done}, 128'd0);
        check("s5_flush_cnt2", flush_cnt, 128'd2);

        // Reset in the middle of a write
        enq(16'h8000, D_4);
        enq(16'h8100, D_A);
        wait_write("s6_write");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("s6_memwrite0", {127'b0, mem_write}, 128'd0);
        check("s6_count0", {125'b0, count}, 128'd0);
        lkp_addr = 16'h8000;
        #1;
        check("s6_lkp_a", {127'b0, lkp_hit}, 128'd0);
        lkp_addr = 16'h8100;
        #1;
        check("s6_lkp_b", {127'b0, lkp_hit}, 128'd0);
        resp();
        check("s6_late_count", {125'b0, count}, 128'd0);
        check("s6_late_memwrite", {127'b0, mem_write}, 128'd0);
        step();
        check("s6_still_idle", {127'b0, mem_write}, 128'd0);

        check("sb_empty", exp_q.size(), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
